// File: rtl/sequenciador_excess_3.sv
// Digit-serial BCD -> excess-3 converter: one shared 4-bit +3 adder walks the
// packed word from digit 0 upward, with valid/ready handshakes on both sides.
module sequenciador_excess_3 #(
  parameter int NUM_DIGITOS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4*NUM_DIGITOS-1:0] entrada,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     cancelar,
  output logic [4*NUM_DIGITOS-1:0] saida,
  output logic                     erro,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     ocupado
);

  localparam int IW = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
  localparam logic [IW-1:0] ULTIMO = IW'(NUM_DIGITOS - 1);

  typedef enum logic [1:0] {OCIOSO, CONVERTE, PRONTO} estado_t;

  estado_t                  estado_q, estado_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [4*NUM_DIGITOS-1:0] dado_q, dado_d;
  logic [4*NUM_DIGITOS-1:0] saida_q, saida_d;
  logic                     erro_q, erro_d;
  logic [3:0]               digito, soma;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= OCIOSO;
      idx_q    <= '0;
      dado_q   <= '0;
      saida_q  <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      dado_q   <= dado_d;
      saida_q  <= saida_d;
      erro_q   <= erro_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    idx_d    = idx_q;
    dado_d   = dado_q;
    saida_d  = saida_q;
    erro_d   = erro_q;
    digito   = dado_q[4*idx_q +: 4];
    soma     = digito + 4'd3;
    case (estado_q)
      OCIOSO: begin
        // acceptance outranks cancelar, which is meaningless here anyway
        if (in_valid) begin
          dado_d   = entrada;
          idx_d    = '0;
          erro_d   = 1'b0;
          estado_d = CONVERTE;
        end
      end
      CONVERTE: begin
        if (cancelar) begin
          estado_d = OCIOSO;
        end else begin
          saida_d[4*idx_q +: 4] = soma;
          if (digito > 4'd9) erro_d = 1'b1;
          if (idx_q == ULTIMO) estado_d = PRONTO;
          else                 idx_d    = idx_q + 1'b1;
        end
      end
      PRONTO: begin
        if (out_ready) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign in_ready  = (estado_q == OCIOSO);
  assign out_valid = (estado_q == PRONTO);
  assign ocupado   = (estado_q != OCIOSO);
  assign saida     = saida_q;
  assign erro      = erro_q;

endmodule

// File: tb/tb_sequenciador_excess_3.sv
// Bench for sequenciador_excess_3: directed vector table, reset/cancel
// sequences and random words checked against a digit-arithmetic model.
module tb_sequenciador_excess_3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] entrada;
  logic        in_valid, in_ready, cancelar;
  logic [15:0] saida;
  logic        erro, out_valid, out_ready, ocupado;

  int vectors = 0;
  int miscompares = 0;

  sequenciador_excess_3 #(.NUM_DIGITOS(4)) dut (
    .clk(clk), .rst(rst), .entrada(entrada), .in_valid(in_valid),
    .in_ready(in_ready), .cancelar(cancelar), .saida(saida), .erro(erro),
    .out_valid(out_valid), .out_ready(out_ready), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    logic [15:0] exp_s;
    logic        exp_e;
    int          espera;
  } vetor_t;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_saida(input logic [15:0] w);
    int r = 0;
    for (int i = 0; i < 4; i++) r += (((int'(w) >> (4*i)) % 16 + 3) % 16) << (4*i);
    return 16'(r);
  endfunction

  function automatic logic ref_erro(input logic [15:0] w);
    for (int i = 0; i < 4; i++) if (((int'(w) >> (4*i)) % 16) > 9) return 1'b1;
    return 1'b0;
  endfunction

  // Starts at a negedge; ends at a negedge with the block back in OCIOSO.
  task automatic aplica(input logic [15:0] w, input logic [15:0] exp_s,
                        input logic exp_e, input int espera);
    int lat, n;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready antes", in_ready, 1);
    entrada = w; in_valid = 1; cancelar = 1; out_ready = (espera == 0);
    @(posedge clk);
    @(negedge clk);
    cancelar = 0;
    lat = 0;
    // competing words during conversion must be ignored
    while (!out_valid && lat < 20) begin
      entrada = 16'($urandom);
      chk("in_ready convertendo", in_ready, 0);
      @(negedge clk); lat++;
    end
    in_valid = 0;
    chk("latencia", lat, 4);
    chk("out_valid", out_valid, 1);
    chk("saida", saida, exp_s);
    chk("erro", erro, exp_e);
    for (int i = 0; i < espera; i++) begin
      in_valid = 1; entrada = 16'($urandom); cancelar = 1;
      @(negedge clk);
      chk("out_valid retido", out_valid, 1);
      chk("saida retida", saida, exp_s);
      chk("erro retido", erro, exp_e);
      chk("in_ready retido", in_ready, 0);
    end
    in_valid = 0; cancelar = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("in_ready apos", in_ready, 1);
    chk("out_valid apos", out_valid, 0);
    chk("saida apos", saida, exp_s);
    chk("erro apos", erro, exp_e);
  endtask

  vetor_t tab[$];
  int     pulsos;

  initial begin
    rst = 1; entrada = 0; in_valid = 0; cancelar = 0; out_ready = 0;
    tab.push_back('{16'h1234, 16'h4567, 1'b0, 0});
    tab.push_back('{16'h0999, 16'h3CCC, 1'b0, 0});
    tab.push_back('{16'h00A9, 16'h33DC, 1'b1, 5});
    tab.push_back('{16'h9000, 16'hC333, 1'b0, 1});
    tab.push_back('{16'hFFFF, 16'h2222, 1'b1, 2});
    tab.push_back('{16'h0000, 16'h3333, 1'b0, 0});

    #12;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst ocupado", ocupado, 0);
    chk("rst saida", saida, 0);
    chk("rst erro", erro, 0);
    @(negedge clk);
    rst = 0;

    foreach (tab[k]) aplica(tab[k].w, tab[k].exp_s, tab[k].exp_e, tab[k].espera);

    // reset after two digits have been written
    entrada = 16'h1234; in_valid = 1;
    @(posedge clk);
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst meio saida", saida, 0);
    chk("rst meio erro", erro, 0);
    chk("rst meio out_valid", out_valid, 0);
    chk("rst meio in_ready", in_ready, 1);
    chk("rst meio ocupado", ocupado, 0);
    @(negedge clk);
    rst = 0;
    pulsos = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (out_valid) pulsos++; end
    chk("out_valid pos reset", pulsos, 0);
    aplica(16'h5678, 16'h89AB, 1'b0, 0);

    // cancel in the second CONVERTE cycle
    entrada = 16'h1111; in_valid = 1;
    @(posedge clk);
    @(negedge clk); in_valid = 0;
    @(negedge clk); cancelar = 1;
    @(negedge clk); cancelar = 0;
    chk("cancel in_ready", in_ready, 1);
    chk("cancel ocupado", ocupado, 0);
    pulsos = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (out_valid) pulsos++; end
    chk("out_valid pos cancel", pulsos, 0);
    aplica(16'h0000, 16'h3333, 1'b0, 0);

    for (int k = 0; k < 20; k++) begin
      logic [15:0] w;
      w = 16'($urandom);
      aplica(w, ref_saida(w), ref_erro(w), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
